// File: rtl/csa_resolve_pipe.sv
// Two-stage carry-propagate adder that resolves a carry-save (sum, carry) pair into binary.
// Optional macro CSA_RESOLVE_ZERO_FLAG_EN adds a registered result_zero output.
module csa_resolve_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SPLIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
    output logic             result_zero,
`endif
    output logic             carry_out
);
    localparam int unsigned HW = WIDTH - SPLIT;

    logic             v1;
    logic             v2;
    logic             s2_ready;
    logic             load1;
    logic             load2;
    logic [SPLIT:0]   lo;
    logic [HW:0]      hi;
    logic [SPLIT-1:0] lo_reg;
    logic             c1;
    logic [HW-1:0]    sum_hi;
    logic [HW-1:0]    carry_hi;

    assign s2_ready  = !v2 || out_ready;
    assign in_ready  = !v1 || s2_ready;
    assign out_valid = v2;
    assign load1     = in_valid && in_ready;
    assign load2     = v1 && s2_ready;

    assign lo = {1'b0, sum_in[SPLIT-1:0]} + {1'b0, carry_in[SPLIT-1:0]};
    assign hi = {1'b0, sum_hi} + {1'b0, carry_hi} + {{HW{1'b0}}, c1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= load1 || (v1 && !s2_ready);
            v2 <= load2 || (v2 && !out_ready);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_reg   <= '0;
            c1       <= 1'b0;
            sum_hi   <= '0;
            carry_hi <= '0;
        end else if (load1) begin
            lo_reg   <= lo[SPLIT-1:0];
            c1       <= lo[SPLIT];
            sum_hi   <= sum_in[WIDTH-1:SPLIT];
            carry_hi <= carry_in[WIDTH-1:SPLIT];
        end
    end

    // Stage 2 only loads when the consumer has freed the slot, so outputs hold under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            carry_out <= 1'b0;
        end else if (load2) begin
            result    <= {hi[HW-1:0], lo_reg};
            carry_out <= hi[HW];
        end
    end

`ifdef CSA_RESOLVE_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_zero <= 1'b0;
        end else if (load2) begin
            result_zero <= ({hi[HW-1:0], lo_reg} == '0);
        end
    end
`endif
endmodule

// File: tb/tb_csa_resolve_pipe.sv
// Scoreboard bench for csa_resolve_pipe: the driver pushes expected results on acceptance,
// a negedge monitor compares them against the DUT output in order.
module tb_csa_resolve_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] sum_in = '0;
    logic [31:0] carry_in = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;
    logic        carry_out;
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
    logic        result_zero;
`endif

    // Expected entry layout: {zero_flag, carry_out, result}
    logic [33:0] q[$];
    int n_cmp = 0;
    int n_fail = 0;

    csa_resolve_pipe #(.WIDTH(32), .SPLIT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
        .result_zero (result_zero),
`endif
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {(s[31:0] == 32'h0), s};
    endfunction

    // Output monitor: pop on handoff, otherwise check the held value against the head entry.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected none", result);
            end else begin
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
                check("out_pair", {30'h0, result_zero, carry_out, result}, {30'h0, q[0]});
`else
                check("out_pair", {31'h0, carry_out, result}, {31'h0, q[0][32:0]});
`endif
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    // Caller is just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [33:0] e);
        bit ok = 0;
        sum_in   = a;
        carry_in = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (ok) q.push_back(e);
        else begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_carry_out", carry_out, 0);
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
        check("rst_result_zero", result_zero, 0);
`endif
    endtask

    initial begin
        longint t0;
        logic [31:0] a;
        logic [31:0] b;

        #1;
        check_reset_outputs();
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single pair crossing the split; checks 2-cycle latency
        out_ready = 1'b1;
        send(32'h0000FFFF, 32'h00000002, {1'b0, 1'b0, 32'h00010001});
        check("lat1_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat2_out_valid", out_valid, 1);
        drain();

        send(32'hFFFFFFFF, 32'h00000002, {1'b0, 1'b1, 32'h00000001});
        send(32'h80000000, 32'h80000000, {1'b1, 1'b1, 32'h00000000});
        send(32'h12345678, 32'h0000F0F0, {1'b0, 1'b0, 32'h12354768});
        drain();

        // Backpressure: out_ready low for 4 cycles while streaming k, 2k
        out_ready = 1'b0;
        fork
            begin
                for (int k = 1; k <= 6; k++) send(k, 2 * k, {2'b00, 32'(3 * k)});
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
                @(posedge clk);
                @(posedge clk);
                #1;
                check("stall4_in_ready", in_ready, 0);
                out_ready = 1'b1;
            end
        join
        drain();

        // Back-to-back random: one acceptance per cycle
        t0 = $time;
        for (int i = 0; i < 100; i++) begin
            a = $urandom;
            b = $urandom;
            send(a, b, model(a, b));
        end
        check("throughput_time", $time - t0, 1000);
        drain();

        // Reset with two pairs in flight
        out_ready = 1'b0;
        send(32'h00000011, 32'h00000022, {2'b00, 32'h00000033});
        send(32'h00000044, 32'h00000055, {2'b00, 32'h00000099});
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        check_reset_outputs();
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send(32'h0000FFFF, 32'h0000FFFF, {1'b0, 1'b0, 32'h0001FFFE});
        check("rst_lat1_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("rst_lat2_out_valid", out_valid, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
